// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one main data memory between the instruction cache (read-only
// port I) and the data cache (read/write port D). Requests are serialised
// with a round-robin policy: one memory transaction at a time, and the
// response plus a busywait handshake go back to the owning cache.
//
// Ports
//   CLK, RESET                      clock, synchronous active-high reset
//   I_READ, I_ADDRESS               icache refill request (level, held)
//   I_READDATA, I_BUSYWAIT          icache response block and stall
//   D_READ, D_WRITE, D_ADDRESS,
//   D_WRITEDATA                     dcache request (write wins if both set)
//   D_READDATA, D_BUSYWAIT          dcache response block and stall
//   MEM_READ, MEM_WRITE,
//   MEM_ADDRESS, MEM_WRITEDATA      registered memory command
//   MEM_READDATA, MEM_BUSYWAIT      memory response block and busy
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  I_READ,
    input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
    output logic [DATA_WIDTH-1:0] I_READDATA,
    output logic                  I_BUSYWAIT,
    input  logic                  D_READ,
    input  logic                  D_WRITE,
    input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
    input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
    output logic [DATA_WIDTH-1:0] D_READDATA,
    output logic                  D_BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
    output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
    input  logic [DATA_WIDTH-1:0] MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM_I,
        ST_MEM_D,
        ST_DONE_I,
        ST_DONE_D
    } state_t;

    state_t                r_state;
    logic                  r_last_grant_d;  // 1: D was granted most recently
    logic                  r_seen_busy;     // memory has acknowledged with busy
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_writedata;
    logic [DATA_WIDTH-1:0] r_i_readdata;
    logic [DATA_WIDTH-1:0] r_d_readdata;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_i;
    logic w_grant_d;
    logic w_complete;

    assign w_i_req = I_READ;
    assign w_d_req = D_READ | D_WRITE;

    // On a tie the port that did not win last time gets the memory.
    assign w_grant_i = w_i_req & (~w_d_req | r_last_grant_d);
    assign w_grant_d = w_d_req & ~w_grant_i;

    // A transaction finishes only after the memory has shown busy at least
    // once, so a busy flag that lags the strobe cannot end it early.
    assign w_complete = r_seen_busy & ~MEM_BUSYWAIT;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state         <= ST_IDLE;
            r_last_grant_d  <= 1'b1;
            r_seen_busy     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_i_readdata    <= '0;
            r_d_readdata    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_i) begin
                        r_mem_read     <= 1'b1;
                        r_mem_write    <= 1'b0;
                        r_mem_address  <= I_ADDRESS;
                        r_last_grant_d <= 1'b0;
                        r_seen_busy    <= 1'b0;
                        r_state        <= ST_MEM_I;
                    end else if (w_grant_d) begin
                        // Write takes priority when both D strobes are high.
                        r_mem_read      <= ~D_WRITE;
                        r_mem_write     <= D_WRITE;
                        r_mem_address   <= D_ADDRESS;
                        r_mem_writedata <= D_WRITEDATA;
                        r_last_grant_d  <= 1'b1;
                        r_seen_busy     <= 1'b0;
                        r_state         <= ST_MEM_D;
                    end
                end

                ST_MEM_I: begin
                    if (MEM_BUSYWAIT) begin
                        r_seen_busy <= 1'b1;
                    end else if (w_complete) begin
                        r_i_readdata <= MEM_READDATA;
                        r_mem_read   <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_state      <= ST_DONE_I;
                    end
                end

                ST_MEM_D: begin
                    if (MEM_BUSYWAIT) begin
                        r_seen_busy <= 1'b1;
                    end else if (w_complete) begin
                        if (r_mem_read) begin
                            r_d_readdata <= MEM_READDATA;
                        end
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= ST_DONE_D;
                    end
                end

                ST_DONE_I,
                ST_DONE_D: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    // Stall released only for the single DONE cycle of the owning port.
    assign I_BUSYWAIT = w_i_req & (r_state != ST_DONE_I);
    assign D_BUSYWAIT = w_d_req & (r_state != ST_DONE_D);

    assign I_READDATA    = r_i_readdata;
    assign D_READDATA    = r_d_readdata;
    assign MEM_READ      = r_mem_read;
    assign MEM_WRITE     = r_mem_write;
    assign MEM_ADDRESS   = r_mem_address;
    assign MEM_WRITEDATA = r_mem_writedata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with a behavioural memory whose busy
// duration is set per transaction. Single-port transactions come from a
// vector table; arbitration, reset-abort and address-hold cases are
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          I_READ;
    logic [AW-1:0] I_ADDRESS;
    logic [DW-1:0] I_READDATA;
    logic          I_BUSYWAIT;
    logic          D_READ;
    logic          D_WRITE;
    logic [AW-1:0] D_ADDRESS;
    logic [DW-1:0] D_WRITEDATA;
    logic [DW-1:0] D_READDATA;
    logic          D_BUSYWAIT;
    logic          MEM_READ;
    logic          MEM_WRITE;
    logic [AW-1:0] MEM_ADDRESS;
    logic [DW-1:0] MEM_WRITEDATA;
    logic [DW-1:0] MEM_READDATA;
    logic          MEM_BUSYWAIT;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .I_READ       (I_READ),
        .I_ADDRESS    (I_ADDRESS),
        .I_READDATA   (I_READDATA),
        .I_BUSYWAIT   (I_BUSYWAIT),
        .D_READ       (D_READ),
        .D_WRITE      (D_WRITE),
        .D_ADDRESS    (D_ADDRESS),
        .D_WRITEDATA  (D_WRITEDATA),
        .D_READDATA   (D_READDATA),
        .D_BUSYWAIT   (D_BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    // ---------------- behavioural memory ----------------
    // Raises busy on the falling edge after a strobe appears, keeps it for
    // mem_lat rising edges, then returns data / stores the write.
    logic [DW-1:0] mem_arr [64];
    int            mem_lat;
    int            mem_cnt;
    bit            mem_started;

    always @(negedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= 32'hC0DE0000 + 32'(i);
            mem_arr[5]   <= 32'hDEADBEEF;
            mem_started  <= 1'b0;
            MEM_BUSYWAIT <= 1'b0;
            MEM_READDATA <= '0;
        end else if (!(MEM_READ || MEM_WRITE)) begin
            mem_started  <= 1'b0;
            MEM_BUSYWAIT <= 1'b0;
        end else if (!mem_started) begin
            mem_started  <= 1'b1;
            mem_cnt      <= mem_lat;
            MEM_BUSYWAIT <= 1'b1;
        end else if (MEM_BUSYWAIT) begin
            mem_cnt <= mem_cnt - 1;
            if (mem_cnt == 1) begin
                MEM_BUSYWAIT <= 1'b0;
                if (MEM_WRITE) mem_arr[MEM_ADDRESS] <= MEM_WRITEDATA;
                else           MEM_READDATA <= mem_arr[MEM_ADDRESS];
            end
        end
    end

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_d;
        bit          rd;
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_rdata;
    } vec_t;

    // Single-port transaction; called at a falling edge, returns at one.
    task automatic do_txn(input vec_t v, input int idx);
        int   stall = 0;
        int   strobe_cycles = 0;
        bit   seen_op = 0;
        bit   other_bad = 0;
        bit   both_bad = 0;
        bit   done = 0;
        bit   wr_eff;
        logic op_rd = 0, op_wr = 0;
        logic [AW-1:0] op_addr = '0;
        logic [DW-1:0] op_wdata = '0;
        logic [DW-1:0] rdata;
        wr_eff  = v.is_d & v.wr;
        mem_lat = v.lat;
        if (v.is_d) begin
            D_READ = v.rd; D_WRITE = v.wr; D_ADDRESS = v.addr; D_WRITEDATA = v.wdata;
        end else begin
            I_READ = 1'b1; I_ADDRESS = v.addr;
        end
        for (int c = 0; c < 60; c++) begin
            #1;
            if (MEM_READ && MEM_WRITE) both_bad = 1;
            if (MEM_READ || MEM_WRITE) begin
                strobe_cycles++;
                if (!seen_op) begin
                    seen_op = 1; op_rd = MEM_READ; op_wr = MEM_WRITE;
                    op_addr = MEM_ADDRESS; op_wdata = MEM_WRITEDATA;
                end
            end
            if (v.is_d ? I_BUSYWAIT : D_BUSYWAIT) other_bad = 1;
            if (!(v.is_d ? D_BUSYWAIT : I_BUSYWAIT)) begin
                done = 1;
                break;
            end
            stall++;
            @(negedge CLK);
        end
        rdata = v.is_d ? D_READDATA : I_READDATA;
        $display("txn %0d port=%s wr=%0d addr=%h lat=%0d stall=%0d strobe=%0d rdata=%h",
                 idx, v.is_d ? "D" : "I", wr_eff, v.addr, v.lat, stall, strobe_cycles, rdata);
        chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d_stall", idx), 32'(stall), 32'(v.lat + 2));
        chk($sformatf("v%0d_strobe_len", idx), 32'(strobe_cycles), 32'(v.lat + 1));
        chk($sformatf("v%0d_mem_read", idx), 32'(op_rd), 32'(!wr_eff));
        chk($sformatf("v%0d_mem_write", idx), 32'(op_wr), 32'(wr_eff));
        chk($sformatf("v%0d_mem_addr", idx), 32'(op_addr), 32'(v.addr));
        if (wr_eff) chk($sformatf("v%0d_mem_wdata", idx), op_wdata, v.wdata);
        chk($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
        chk($sformatf("v%0d_other_busy", idx), 32'(other_bad), 32'd0);
        chk($sformatf("v%0d_strobe_overlap", idx), 32'(both_bad), 32'd0);
        I_READ = 0; D_READ = 0; D_WRITE = 0;
        @(negedge CLK);
    endtask

    // Both ports request together and keep requesting until each has been
    // served n_i / n_d times. Records service order (0=I, 1=D) as bits.
    task automatic run_both(input string name, input int n_i, input int n_d, input bit d_wr,
                            input int lat, input logic [7:0] exp_order, input int exp_cycles);
        int         rem_i = n_i;
        int         rem_d = n_d;
        int         pos = 0;
        int         cyc = -1;
        bit         overlap = 0;
        logic [7:0] order = '0;
        mem_lat = lat;
        I_READ  = (rem_i > 0);
        if (d_wr) D_WRITE = (rem_d > 0); else D_READ = (rem_d > 0);
        for (int c = 0; c < 200; c++) begin
            #1;
            if (MEM_READ && MEM_WRITE) overlap = 1;
            if (I_READ && !I_BUSYWAIT) begin
                pos++; rem_i--;
                if (rem_i == 0) I_READ = 0;
            end
            if ((D_READ || D_WRITE) && !D_BUSYWAIT) begin
                order[pos] = 1'b1; pos++; rem_d--;
                if (rem_d == 0) begin D_READ = 0; D_WRITE = 0; end
            end
            if (rem_i == 0 && rem_d == 0) begin
                cyc = c;
                break;
            end
            @(negedge CLK);
        end
        $display("seq %s served=%0d order=%b cycles=%0d", name, pos, order, cyc);
        chk({name, "_order"}, 32'(order), 32'(exp_order));
        chk({name, "_cycles"}, 32'(cyc), 32'(exp_cycles));
        chk({name, "_overlap"}, 32'(overlap), 32'd0);
        I_READ = 0; D_READ = 0; D_WRITE = 0;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
    endtask

    vec_t vecs [7];

    initial begin
        bit addr_bad;
        bit done;
        int cyc;

        vecs[0] = '{is_d:0, rd:1, wr:0, addr:6'h05, wdata:32'h0,        lat:5, exp_rdata:32'hDEADBEEF};
        vecs[1] = '{is_d:1, rd:0, wr:1, addr:6'h2A, wdata:32'h01234567, lat:3, exp_rdata:32'h00000000};
        vecs[2] = '{is_d:1, rd:1, wr:0, addr:6'h2A, wdata:32'h0,        lat:1, exp_rdata:32'h01234567};
        vecs[3] = '{is_d:0, rd:1, wr:0, addr:6'h2A, wdata:32'h0,        lat:2, exp_rdata:32'h01234567};
        vecs[4] = '{is_d:1, rd:1, wr:0, addr:6'h07, wdata:32'h0,        lat:4, exp_rdata:32'hC0DE0007};
        vecs[5] = '{is_d:1, rd:1, wr:1, addr:6'h11, wdata:32'h5A5AA5A5, lat:2, exp_rdata:32'hC0DE0007};
        vecs[6] = '{is_d:0, rd:1, wr:0, addr:6'h3F, wdata:32'h0,        lat:1, exp_rdata:32'hC0DE003F};

        RESET = 1'b1; I_READ = 0; I_ADDRESS = '0; D_READ = 0; D_WRITE = 0;
        D_ADDRESS = '0; D_WRITEDATA = '0; mem_lat = 1;
        @(negedge CLK);
        do_reset();
        #1;
        $display("reset state mem_rd=%0d mem_wr=%0d addr=%h wdata=%h irdata=%h drdata=%h",
                 MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, I_READDATA, D_READDATA);
        chk("rst_mem_read", 32'(MEM_READ), 32'd0);
        chk("rst_mem_write", 32'(MEM_WRITE), 32'd0);
        chk("rst_mem_addr", 32'(MEM_ADDRESS), 32'd0);
        chk("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
        chk("rst_i_rdata", I_READDATA, 32'd0);
        chk("rst_d_rdata", D_READDATA, 32'd0);
        chk("rst_i_busy", 32'(I_BUSYWAIT), 32'd0);
        chk("rst_d_busy", 32'(D_BUSYWAIT), 32'd0);
        @(negedge CLK);

        for (int i = 0; i < 7; i++) do_txn(vecs[i], i);

        // Tie right after reset: I first (last grant resets to D), then D.
        do_reset();
        run_both("tie_after_reset", 1, 1, 1'b0, 2, 8'b10, 9);
        // Serve I alone so I is the last grant; the next tie then goes to D.
        do_txn('{is_d:0, rd:1, wr:0, addr:6'h05, wdata:32'h0, lat:1, exp_rdata:32'hDEADBEEF}, 7);
        run_both("tie_after_i", 1, 1, 1'b0, 2, 8'b01, 9);

        // Six back-to-back transactions with both ports held high.
        do_reset();
        run_both("alternate6", 3, 3, 1'b1, 1, 8'b101010, 23);

        // Reset in the middle of a D write with busy still pending.
        mem_lat = 5;
        D_WRITE = 1; D_ADDRESS = 6'h15; D_WRITEDATA = 32'hFEEDF00D;
        repeat (3) @(negedge CLK);
        #1;
        chk("abort_pre_mem_write", 32'(MEM_WRITE), 32'd1);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        $display("abort after reset mem_wr=%0d mem_rd=%0d d_busy=%0d", MEM_WRITE, MEM_READ, D_BUSYWAIT);
        chk("abort_mem_write", 32'(MEM_WRITE), 32'd0);
        chk("abort_mem_read", 32'(MEM_READ), 32'd0);
        chk("abort_d_busy", 32'(D_BUSYWAIT), 32'd1);
        done = 0; cyc = 0;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) #1;
            if (!D_BUSYWAIT) begin done = 1; break; end
            cyc++;
            @(negedge CLK);
        end
        $display("abort retry done=%0d stall=%0d stored=%h", done, cyc, mem_arr[6'h15]);
        chk("abort_retry_done", 32'(done), 32'd1);
        chk("abort_retry_stall", 32'(cyc), 32'd7);
        D_WRITE = 0;
        @(negedge CLK);
        chk("abort_retry_stored", mem_arr[6'h15], 32'hFEEDF00D);

        // Address changes mid-transaction must not reach the memory.
        mem_lat = 4;
        D_READ = 1; D_ADDRESS = 6'h10;
        addr_bad = 0; done = 0; cyc = 0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if ((MEM_READ || MEM_WRITE) && MEM_ADDRESS !== 6'h10) addr_bad = 1;
            if (!D_BUSYWAIT) begin done = 1; break; end
            cyc++;
            if (c == 2) D_ADDRESS = 6'h11;
            @(negedge CLK);
        end
        $display("addr_hold done=%0d stall=%0d addr_bad=%0d rdata=%h", done, cyc, addr_bad, D_READDATA);
        chk("addr_hold_done", 32'(done), 32'd1);
        chk("addr_hold_addr", 32'(addr_bad), 32'd0);
        chk("addr_hold_stall", 32'(cyc), 32'd6);
        chk("addr_hold_rdata", D_READDATA, 32'hC0DE0010);
        D_READ = 0;
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
